inst_fetch: RTL and testbench

Instruction fetch unit that produces the 32-bit instruction word consumed by the decode stage. It owns the PC, issues in-order read requests to instruction memory over a req/gnt/rvalid interface, and buffers returned words in a small FIFO. The FIFO presents instructions to decode with a valid/ready handshake. Branch redirects from the execute stage flush the FIFO and discard in-flight responses.

---
 rtl/inst_fetch.sv | 179 +++++++++++++++++
 tb/tb_inst_fetch.sv | 306 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/inst_fetch.sv
`timescale 1ns/1ps
// Small circular FIFO with synchronous flush; the head entry is read combinationally.
// Latency: a pushed entry is visible at the head on the cycle after the push.
// Backpressure: a push is taken when not full, or when a pop happens in the same cycle.
module fetch_fifo #(
    parameter int WIDTH = 32,
    parameter int DEPTH = 2
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   flush,
    input  logic                   push_vld,
    input  logic [WIDTH-1:0]       push_dat,
    input  logic                   pop_rdy,
    output logic [WIDTH-1:0]       head_dat,
    output logic [$clog2(DEPTH):0] count,
    output logic                   empty,
    output logic                   full
);
    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic             do_push;
    logic             do_pop;

    assign empty    = (count == '0);
    assign full     = (count == (AW+1)'(DEPTH));
    assign do_pop   = pop_rdy && !empty;
    assign do_push  = push_vld && (!full || do_pop);
    assign head_dat = mem[rd_ptr];

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
            count <= count + (AW+1)'(do_push) - (AW+1)'(do_pop);
        end
    end

    always_ff @(posedge clk) begin
        if (do_push && !flush) mem[wr_ptr] <= push_dat;
    end
endmodule

// Instruction fetch: owns the PC, issues in-order imem reads, buffers words for decode.
// Latency: rvalid to inst_valid is 1 cycle; redirect empties the output on the next cycle.
// Backpressure: requests stop once buffered plus live outstanding words reach DEPTH.
module inst_fetch #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter int          DEPTH    = 2
) (
    input  logic        clk,
    input  logic        reset,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_gnt,
    input  logic        imem_rvalid,
    input  logic [31:0] imem_rdata,
    input  logic        redirect,
    input  logic [31:0] redirect_target,
    output logic        inst_valid,
    input  logic        inst_ready,
    output logic [31:0] inst,
    output logic [31:0] inst_pc
);
    localparam int FW = $clog2(DEPTH) + 1;
    // Owed responses can reach 2*DEPTH: DEPTH being discarded plus DEPTH live.
    localparam int CW = $clog2(DEPTH) + 2;

    typedef enum logic [1:0] {IDLE = 2'd0, RUN = 2'd1, FLUSH = 2'd2} state_t;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] word;
    } fetch_ent_t;

    state_t        state;
    logic [31:0]   pc;
    logic [CW-1:0] out_cnt;
    logic [CW-1:0] disc_cnt;
    logic [CW-1:0] out_cnt_nxt;
    logic [CW-1:0] disc_cnt_nxt;
    logic [CW-1:0] live_cnt;
    logic          grant;
    logic          drop_owed;
    logic          keep;

    fetch_ent_t    ifq_push_dat;
    fetch_ent_t    ifq_head;
    logic [FW-1:0] ifq_count;
    logic          ifq_empty;
    logic          ifq_full;
    logic [31:0]   pcq_head;
    logic [FW-1:0] pcq_count;
    logic          pcq_empty;
    logic          pcq_full;
    logic          unused_sig;

    assign live_cnt  = out_cnt - disc_cnt;
    assign imem_req  = (state != IDLE) && !redirect &&
                       ((CW'(ifq_count) + live_cnt) < CW'(DEPTH));
    assign imem_addr = pc;
    assign grant     = imem_req && imem_gnt;

    // Stale words are always older than live ones, so they drain first.
    assign drop_owed = imem_rvalid && (disc_cnt != '0);
    assign keep      = imem_rvalid && !drop_owed && !redirect;

    assign out_cnt_nxt  = out_cnt + CW'(grant) - CW'(imem_rvalid);
    assign disc_cnt_nxt = redirect ? out_cnt_nxt : (disc_cnt - CW'(drop_owed));

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state    <= IDLE;
            pc       <= RESET_PC;
            out_cnt  <= '0;
            disc_cnt <= '0;
        end else begin
            out_cnt  <= out_cnt_nxt;
            disc_cnt <= disc_cnt_nxt;
            if (redirect)   pc <= {redirect_target[31:2], 2'b00};
            else if (grant) pc <= pc + 32'd4;
            case (state)
                IDLE: state <= RUN;
                RUN, FLUSH: begin
                    if (redirect)
                        state <= (out_cnt_nxt != '0) ? FLUSH : RUN;
                    else if (state == FLUSH && disc_cnt_nxt == '0)
                        state <= RUN;
                end
                default: state <= IDLE;
            endcase
        end
    end

    fetch_fifo #(.WIDTH(32), .DEPTH(DEPTH)) u_pcq (
        .clk      (clk),
        .reset    (reset),
        .flush    (redirect),
        .push_vld (grant),
        .push_dat (pc),
        .pop_rdy  (keep),
        .head_dat (pcq_head),
        .count    (pcq_count),
        .empty    (pcq_empty),
        .full     (pcq_full)
    );

    assign ifq_push_dat = {pcq_head, imem_rdata};

    fetch_fifo #(.WIDTH(64), .DEPTH(DEPTH)) u_ifq (
        .clk      (clk),
        .reset    (reset),
        .flush    (redirect),
        .push_vld (keep),
        .push_dat (ifq_push_dat),
        .pop_rdy  (inst_valid && inst_ready),
        .head_dat (ifq_head),
        .count    (ifq_count),
        .empty    (ifq_empty),
        .full     (ifq_full)
    );

    assign inst_valid = !ifq_empty;
    assign inst       = inst_valid ? ifq_head.word : 32'h0;
    assign inst_pc    = inst_valid ? ifq_head.pc   : 32'h0;

    assign unused_sig = ^{redirect_target[1:0], ifq_full, pcq_count, pcq_empty, pcq_full};
endmodule

// File: tb/tb_inst_fetch.sv
`timescale 1ns/1ps
// Bench for inst_fetch: transaction-level model of PC, owed requests and output queue,
// an in-order memory with configurable latency/grant stalls, and directed scenarios.
module tb_inst_fetch;
    localparam logic [31:0] RESET_PC = 32'h0000_0000;
    localparam int          DEPTH    = 2;

    logic        clk = 1'b0;
    logic        reset;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_gnt;
    logic        imem_rvalid;
    logic [31:0] imem_rdata;
    logic        redirect;
    logic [31:0] redirect_target;
    logic        inst_valid;
    logic        inst_ready;
    logic [31:0] inst;
    logic [31:0] inst_pc;

    always #5 clk = ~clk;

    inst_fetch #(.RESET_PC(RESET_PC), .DEPTH(DEPTH)) dut (
        .clk             (clk),
        .reset           (reset),
        .imem_req        (imem_req),
        .imem_addr       (imem_addr),
        .imem_gnt        (imem_gnt),
        .imem_rvalid     (imem_rvalid),
        .imem_rdata      (imem_rdata),
        .redirect        (redirect),
        .redirect_target (redirect_target),
        .inst_valid      (inst_valid),
        .inst_ready      (inst_ready),
        .inst            (inst),
        .inst_pc         (inst_pc)
    );

    typedef struct { logic stale; logic [31:0] pc; } owed_t;
    typedef struct { logic [31:0] addr; int due; } mreq_t;

    owed_t       m_owed[$];
    logic [63:0] m_fifo[$];
    logic [31:0] m_pc;
    bit          m_started;
    bit          m_req;

    mreq_t       mem_q[$];
    int          mem_lat = 1;
    bit          gnt_en  = 1'b1;
    logic [31:0] log_addr[$];
    logic [31:0] log_pc[$];

    int checks   = 0;
    int failures = 0;
    int cyc      = 0;

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return ~a ^ 32'h5A5A_0000;
    endfunction

    function automatic int live_owed();
        int n = 0;
        foreach (m_owed[i]) if (!m_owed[i].stale) n++;
        return n;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic chk_addr(input string name, input int idx, input logic [31:0] exp);
        if (idx < log_addr.size()) chk(name, log_addr[idx], exp);
        else begin
            checks++;
            failures++;
            $display("FAIL %s: only %0d grants seen, wanted index %0d = %h", name, log_addr.size(), idx, exp);
        end
    endtask

    task automatic chk_pc(input string name, input int idx, input logic [31:0] exp);
        if (idx < log_pc.size()) chk(name, log_pc[idx], exp);
        else begin
            checks++;
            failures++;
            $display("FAIL %s: only %0d instructions seen, wanted index %0d = %h", name, log_pc.size(), idx, exp);
        end
    endtask

    task automatic compare();
        logic [63:0] h;
        m_req = m_started && !redirect && ((m_fifo.size() + live_owed()) < DEPTH);
        h = (m_fifo.size() > 0) ? m_fifo[0] : 64'h0;
        chk("imem_req",   32'(imem_req),   32'(m_req));
        chk("imem_addr",  imem_addr,       m_pc);
        chk("inst_valid", 32'(inst_valid), 32'(m_fifo.size() > 0));
        chk("inst",       inst,            h[31:0]);
        chk("inst_pc",    inst_pc,         h[63:32]);
        if (dut.u_ifq.push_vld)
            chk("ifq_overflow", 32'(dut.u_ifq.full && !dut.u_ifq.pop_rdy && !dut.u_ifq.flush), 32'd0);
    endtask

    task automatic model_edge(input bit rv, input logic [31:0] rdata, input bit rdy,
                              input bit redir, input logic [31:0] tgt, input bit gnt);
        owed_t       o;
        bit          have_new = 1'b0;
        logic [63:0] ent = 64'h0;
        if (rv && m_owed.size() > 0) begin
            o = m_owed.pop_front();
            if (!o.stale && !redir) begin
                have_new = 1'b1;
                ent      = {o.pc, rdata};
            end
        end
        if (redir) begin
            m_fifo.delete();
            foreach (m_owed[i]) m_owed[i].stale = 1'b1;
            m_pc = {tgt[31:2], 2'b00};
        end else begin
            if (m_fifo.size() > 0 && rdy) void'(m_fifo.pop_front());
            if (have_new) m_fifo.push_back(ent);
            if (m_req && gnt) begin
                o.stale = 1'b0;
                o.pc    = m_pc;
                m_owed.push_back(o);
                m_pc = m_pc + 32'd4;
            end
        end
        m_started = 1'b1;
    endtask

    // One clock cycle: drive at negedge, compare, log, advance model and memory.
    task automatic cycle(input bit redir, input logic [31:0] tgt, input bit rdy);
        bit    rv;
        mreq_t r;
        redirect        = redir;
        redirect_target = tgt;
        inst_ready      = rdy;
        imem_gnt        = gnt_en;
        rv = 1'b0;
        if (mem_q.size() > 0) rv = (mem_q[0].due <= cyc);
        imem_rvalid = rv;
        imem_rdata  = rv ? mem_word(mem_q[0].addr) : 32'hDEAD_BEEF;
        #1;
        compare();
        if (inst_valid && inst_ready && !redirect) log_pc.push_back(inst_pc);
        if (rv) void'(mem_q.pop_front());
        if (imem_req && imem_gnt) begin
            r.addr = imem_addr;
            r.due  = cyc + mem_lat;
            mem_q.push_back(r);
            log_addr.push_back(imem_addr);
        end
        model_edge(rv, imem_rdata, rdy, redir, tgt, gnt_en);
        @(negedge clk);
        cyc++;
    endtask

    task automatic do_reset();
        reset           = 1'b0;
        redirect        = 1'b0;
        redirect_target = 32'h0;
        inst_ready      = 1'b0;
        imem_gnt        = 1'b0;
        imem_rvalid     = 1'b0;
        imem_rdata      = 32'h0;
        m_pc      = RESET_PC;
        m_started = 1'b0;
        m_owed.delete();
        m_fifo.delete();
        mem_q.delete();
        log_addr.delete();
        log_pc.delete();
        repeat (2) @(negedge clk);
        chk("rst_req",     32'(imem_req),   32'd0);
        chk("rst_valid",   32'(inst_valid), 32'd0);
        chk("rst_inst",    inst,            32'h0);
        chk("rst_inst_pc", inst_pc,         32'h0);
        chk("rst_addr",    imem_addr,       RESET_PC);
        reset = 1'b1;
    endtask

    initial begin
        int  n;
        bit  found;

        // Streaming with 1-cycle memory.
        mem_lat = 1; gnt_en = 1'b1;
        do_reset();
        repeat (3) cycle(1'b0, 32'h0, 1'b1);
        chk("t1_first_valid", 32'(inst_valid), 32'd1);
        chk("t1_first_pc",    inst_pc,         32'h0);
        chk("t1_first_inst",  inst,            32'hA5A5_FFFF);
        repeat (8) cycle(1'b0, 32'h0, 1'b1);
        chk_addr("t1_addr0", 0, 32'h0);
        chk_addr("t1_addr1", 1, 32'h4);
        chk_addr("t1_addr2", 2, 32'h8);
        chk_pc("t1_pc1", 1, 32'h4);

        // Decode stalled: exactly DEPTH requests, then drain in order.
        do_reset();
        repeat (8) cycle(1'b0, 32'h0, 1'b0);
        chk("t2_grants",   log_addr.size(), 32'd2);
        chk("t2_req_held", 32'(imem_req),   32'd0);
        repeat (8) cycle(1'b0, 32'h0, 1'b1);
        chk_pc("t2_pc0", 0, 32'h0);
        chk_pc("t2_pc1", 1, 32'h4);
        chk_addr("t2_resume", 2, 32'h8);

        // Redirect with two requests in flight.
        do_reset(); mem_lat = 3;
        repeat (3) cycle(1'b0, 32'h0, 1'b1);
        chk("t3_inflight", log_addr.size(), 32'd2);
        cycle(1'b1, 32'h103, 1'b1);
        repeat (12) cycle(1'b0, 32'h0, 1'b1);
        chk_addr("t3_target", 2, 32'h100);
        chk_addr("t3_next",   3, 32'h104);
        chk_pc("t3_first_pc", 0, 32'h100);

        // Redirect in the same cycle as a response and a pop.
        do_reset(); mem_lat = 1;
        found = 1'b0;
        for (int i = 0; i < 20 && !found; i++) begin
            if (inst_valid && mem_q.size() > 0 && mem_q[0].due <= cyc) found = 1'b1;
            else cycle(1'b0, 32'h0, 1'b1);
        end
        if (!found) begin
            checks++;
            failures++;
            $display("FAIL t4_setup: no cycle with rvalid and inst_valid together within 20 cycles");
        end else begin
            cycle(1'b1, 32'h200, 1'b1);
            #1;
            chk("t4_valid",   32'(inst_valid), 32'd0);
            chk("t4_inst",    inst,            32'h0);
            chk("t4_inst_pc", inst_pc,         32'h0);
            chk("t4_no_pop",  log_pc.size(),   32'd0);
            repeat (6) cycle(1'b0, 32'h0, 1'b1);
            chk_pc("t4_after", 0, 32'h200);
        end

        // Address wrap past the top of memory.
        do_reset(); mem_lat = 1;
        repeat (2) cycle(1'b0, 32'h0, 1'b1);
        n = log_addr.size();
        cycle(1'b1, 32'hFFFF_FFFC, 1'b1);
        repeat (10) cycle(1'b0, 32'h0, 1'b1);
        chk_addr("t5_wrap_a", n,     32'hFFFF_FFFC);
        chk_addr("t5_wrap_b", n + 1, 32'h0);
        chk_pc("t5_pc_a", 0, 32'hFFFF_FFFC);
        chk_pc("t5_pc_b", 1, 32'h0);

        // Back-to-back redirects: the second target wins, nothing double-dropped.
        do_reset(); mem_lat = 3;
        repeat (3) cycle(1'b0, 32'h0, 1'b1);
        cycle(1'b1, 32'h300, 1'b1);
        cycle(1'b1, 32'h401, 1'b1);
        repeat (14) cycle(1'b0, 32'h0, 1'b1);
        chk_addr("t6_target", 2, 32'h400);
        chk_pc("t6_pc0", 0, 32'h400);
        chk_pc("t6_pc1", 1, 32'h404);

        // Grant stalls and intermittent decode backpressure.
        do_reset(); mem_lat = 2;
        for (int i = 0; i < 30; i++) begin
            gnt_en = (i % 3 != 1);
            cycle(1'b0, 32'h0, (i % 4 != 3));
        end
        gnt_en = 1'b1;
        chk_pc("t7_pc0", 0, 32'h0);
        chk_pc("t7_pc1", 1, 32'h4);
        chk_pc("t7_pc2", 2, 32'h8);

        // Asynchronous reset while still discarding a stale response.
        do_reset(); mem_lat = 3;
        repeat (3) cycle(1'b0, 32'h0, 1'b1);
        cycle(1'b1, 32'h500, 1'b1);
        gnt_en = 1'b0;
        cycle(1'b0, 32'h0, 1'b1);
        redirect = 1'b0; inst_ready = 1'b1; imem_gnt = 1'b0; imem_rvalid = 1'b0;
        #1;
        chk("t8_req_before",  32'(imem_req), 32'd1);
        chk("t8_addr_before", imem_addr,     32'h500);
        #1 reset = 1'b0;
        #1;
        chk("t8_req",     32'(imem_req),   32'd0);
        chk("t8_valid",   32'(inst_valid), 32'd0);
        chk("t8_inst",    inst,            32'h0);
        chk("t8_inst_pc", inst_pc,         32'h0);
        chk("t8_addr",    imem_addr,       RESET_PC);
        gnt_en = 1'b1; mem_lat = 1;
        do_reset();
        repeat (6) cycle(1'b0, 32'h0, 1'b1);
        chk_addr("t8_restart", 0, RESET_PC);
        chk_pc("t8_pc0", 0, RESET_PC);
        chk_pc("t8_pc1", 1, RESET_PC + 32'd4);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
